ext_unit_pipe: RTL
==================

Name: ext_unit_pipe

Overview:
- Parametrised, registered successor to the single-cycle immediate extender.
- Converts instruction immediate fields (16-bit imm, 26-bit jump index) into DATA_W-bit operands through a one-stage valid/ready pipeline register.
- Supports a prefix mode: a latched upper-immediate word is concatenated with the next immediate, building a full-width constant in two beats.
- Sits between decode and the ALU/PC-select stage of the pipelined datapath.

Parameters:
DATA_W, 32, output operand width; must satisfy DATA_W > JIDX_W+2 and DATA_W >= IMM_W+2
IMM_W, 16, immediate field width
JIDX_W, 26, jump index field width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline flush
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
in_op  input  3  extension mode (see Behaviour)
in_imm  input  IMM_W  immediate field
in_idx  input  JIDX_W  jump index field
in_pc  input  DATA_W  PC+4 of the instruction (JUMP mode)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  DATA_W  extended operand
out_err  output  1  result came from a reserved op
out_pfx_used  output  1  result consumed a pending prefix
pfx_pending  output  1  prefix register holds an unconsumed value

Behaviour:
- Accept: acc = in_valid && in_ready. in_ready = !flush && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Modes (in_op). B is the base value: {pfx, in_imm} (2*IMM_W bits) if pfx_pending, else in_imm. Results are truncated to DATA_W.
  - 0 ZERO: zero-extend B.
  - 1 SIGN: sign-extend B from its MSB.
  - 2 ZERO_SL2: zero-extend B, then shift left 2.
  - 3 SIGN_SL2: sign-extend B, then shift left 2.
  - 4 UPPER: in_imm << IMM_W. Prefix is ignored but cleared.
  - 5 JUMP: {in_pc[DATA_W-1:JIDX_W+2], in_idx, 2'b00}. Prefix is ignored but cleared.
  - 6 PREFIX: pfx <= in_imm, pfx_pending <= 1. No output beat is produced. A second PREFIX overwrites the first; there is a single level only.
  - 7 reserved: out_data = 0, out_err = 1. The prefix is cleared.
- Output register:
  - On acc with a non-PREFIX op, load out_data, out_err and out_pfx_used (= pfx_pending at accept), and set out_valid = 1. Latency is 1 cycle from accept.
  - A non-PREFIX accept clears pfx_pending in the same edge.
  - out_valid clears when out_ready && out_valid and no new load occurs that cycle.
  - Simultaneous pop and push: the register is replaced with no bubble and out_valid stays 1.
  - Accepted PREFIX while out_valid && out_ready: out_valid falls to 0.
- Hold: while out_valid && !out_ready, all output signals remain stable.
- Flush (priority below reset): out_valid, out_err, out_pfx_used, pfx_pending <= 0 and pfx <= 0. out_data keeps its value. in_ready = 0, so no accept occurs in the flush cycle.
- Reset: out_valid = 0, out_data = 0, out_err = 0, out_pfx_used = 0, pfx_pending = 0, pfx = 0. Reset mid-stall drops the held result.
- All state updates occur on the rising clk edge only.

Test Plan:
1. Basic modes (DATA_W=32), each with out_ready=1: op1 imm 0x8001 -> 0xFFFF8001; op3 imm 0x8001 -> 0xFFFE0004; op2 imm 0x8001 -> 0x00020004; op4 imm 0x1234 -> 0x12340000. Each result appears one cycle after accept.
2. Prefix build: op6 imm 0x1234, then op0 imm 0x5678.
   - Exactly one output beat, 0x12345678, with out_pfx_used = 1.
   - pfx_pending goes 1 -> 0.
   - A following op0 imm 0x5678 gives 0x00005678 with out_pfx_used = 0.
3. Prefix with shift: op6 0xFFFF, then op3 imm 0xFFFC -> 0xFFFFFFF0. Then op6 0xAAAA, op6 0x0001, op0 0x0002 -> 0x00010002 (overwrite).
4. Jump: op5, in_pc = 0x00400010, in_idx = 0x0100003 -> 0x0040000C. Same with in_pc = 0xA0000000 and in_idx = 0 -> 0xA0000000.
5. Backpressure:
   - out_ready=0, issue op0 0x0001, then op0 0x0002: first result held stable, in_ready = 0, second not accepted.
   - Raise out_ready with in_valid still high: 0x0002 replaces 0x0001 on the next edge with out_valid continuously 1.
6. Error, flush and reset:
   - op7 -> out_data 0, out_err 1.
   - op6 0x00FF, then flush, then op0 0x0001 -> 0x00000001 and pfx_pending 0.
   - Assert reset while out_valid=1 and out_ready=0 -> out_valid 0 and out_data 0 next cycle.

Source files
------------

// File: rtl/ext_unit_pipe.sv
// Registered immediate/jump-index extender with a one-deep valid/ready output
// register and a single-level upper-immediate prefix for two-beat constants.
module ext_unit_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIDX_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [JIDX_W-1:0] in_idx,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              out_pfx_used,
  output logic              pfx_pending
);

  localparam int unsigned BASE_W = 2 * IMM_W;
  // Wide enough that base extension and the <<2 / <<IMM_W shifts never lose bits
  // before the final truncation to DATA_W.
  localparam int unsigned WIDE_W = DATA_W + BASE_W + 2;

  typedef enum logic [2:0] {
    OP_ZERO     = 3'd0,
    OP_SIGN     = 3'd1,
    OP_ZERO_SL2 = 3'd2,
    OP_SIGN_SL2 = 3'd3,
    OP_UPPER    = 3'd4,
    OP_JUMP     = 3'd5,
    OP_PREFIX   = 3'd6,
    OP_RSVD     = 3'd7
  } op_e;

  op_e                op;
  logic               acc;
  logic               pop;
  logic [IMM_W-1:0]   pfx;
  logic [WIDE_W-1:0]  zext;
  logic [WIDE_W-1:0]  sext;
  logic [DATA_W-1:0]  res_data;
  logic               res_err;
  logic               unused_pc;

  assign op        = op_e'(in_op);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Low PC bits are replaced by the jump index and word alignment.
  assign unused_pc = ^in_pc[JIDX_W+1:0];

  // Base value: prefix concatenated with the immediate when a prefix is pending.
  always_comb begin
    zext = '0;
    sext = '0;
    if (pfx_pending) begin
      zext = WIDE_W'({pfx, in_imm});
      sext = {{(WIDE_W-BASE_W){pfx[IMM_W-1]}}, pfx, in_imm};
    end else begin
      zext = WIDE_W'(in_imm);
      sext = {{(WIDE_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    end
  end

  // Result selection for every op that produces an output beat.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op)
      OP_ZERO:     res_data = DATA_W'(zext);
      OP_SIGN:     res_data = DATA_W'(sext);
      OP_ZERO_SL2: res_data = DATA_W'(zext << 2);
      OP_SIGN_SL2: res_data = DATA_W'(sext << 2);
      OP_UPPER:    res_data = DATA_W'(WIDE_W'(in_imm) << IMM_W);
      OP_JUMP:     res_data = {in_pc[DATA_W-1:JIDX_W+2], in_idx, 2'b00};
      OP_PREFIX:   res_data = '0;
      OP_RSVD:     res_err  = 1'b1;
      default:     res_err  = 1'b1;
    endcase
  end

  // Output register and prefix state; flush keeps out_data but drops everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err      <= 1'b0;
      out_pfx_used <= 1'b0;
      pfx_pending  <= 1'b0;
      pfx          <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_err      <= 1'b0;
      out_pfx_used <= 1'b0;
      pfx_pending  <= 1'b0;
      pfx          <= '0;
    end else begin
      if (acc && op == OP_PREFIX) begin
        pfx         <= in_imm;
        pfx_pending <= 1'b1;
      end
      if (acc && op != OP_PREFIX) begin
        out_valid    <= 1'b1;
        out_data     <= res_data;
        out_err      <= res_err;
        out_pfx_used <= pfx_pending;
        pfx_pending  <= 1'b0;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
